// File: rtl/mem_initiator.sv
//==============================================================================
// Module      : mem_initiator
// Description : Arbitrates thread fetches and s3 loads/stores onto the slowmem
//               strobe/mfc bus; returns tagged read responses to the pipeline.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_initiator #(
    parameter int MEMDELAY = 4,
    parameter int TIMEOUT  = MEMDELAY + 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  fetch_req,
    input  logic [15:0] fetch_addr0,
    input  logic [15:0] fetch_addr1,
    output logic [1:0]  fetch_ack,
    input  logic        d_req,
    input  logic        d_write,
    input  logic        d_pid,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    input  logic [8:0]  d_tag,
    output logic        d_ack,
    output logic        strobe,
    output logic        rnotw,
    output logic [15:0] addr,
    output logic [15:0] wdata,
    input  logic        mfc,
    input  logic [15:0] rdata,
    output logic        resp_valid,
    output logic        resp_pid,
    output logic        resp_load,
    output logic [8:0]  resp_tag,
    output logic [15:0] resp_data,
    output logic        busy,
    output logic        err
);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_WAIT = 1'b1;

    // Counter sized to cover the larger of the two limits so TIMEOUT overrides stay safe.
    localparam int c_WD_MAX = (TIMEOUT > MEMDELAY) ? TIMEOUT : MEMDELAY;
    localparam int c_WD_W   = $clog2(c_WD_MAX + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);
    localparam logic [c_WD_W-1:0] c_WD_ONE  = c_WD_W'(1);

    logic [0:0]        r_state;
    logic [0:0]        w_next_state;
    logic              r_rr;
    logic [c_WD_W-1:0] r_wd;

    logic              r_strobe;
    logic              r_rnotw;
    logic [15:0]       r_addr;
    logic [15:0]       r_wdata;
    logic              r_rec_pid;
    logic              r_rec_load;
    logic [8:0]        r_rec_tag;
    logic              r_resp_valid;
    logic              r_resp_pid;
    logic              r_resp_load;
    logic [8:0]        r_resp_tag;
    logic [15:0]       r_resp_data;
    logic              r_err;

    logic              w_fetch_pid;
    logic              w_fetch_grant;
    logic              w_read_grant;
    logic              w_store_grant;
    logic              w_any_grant;
    logic [15:0]       w_grant_addr;
    logic              w_in_wait;
    logic              w_wd_last;

    assign w_fetch_pid   = fetch_req[r_rr] ? r_rr : ~r_rr;
    assign w_fetch_grant = |fetch_ack;
    assign w_store_grant = d_ack & d_write;
    assign w_read_grant  = w_fetch_grant | (d_ack & ~d_write);
    assign w_any_grant   = w_fetch_grant | d_ack;
    assign w_grant_addr  = d_ack ? d_addr : (fetch_ack[1] ? fetch_addr1 : fetch_addr0);
    assign w_in_wait     = (r_state == c_ST_WAIT);
    assign w_wd_last     = (r_wd == c_WD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // mfc takes precedence over the watchdog when both land in the same cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_read_grant) begin
                    w_next_state = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (mfc || w_wd_last) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // Grants never look at mfc, so a completing read cannot steal a store slot.
    always_comb begin
        fetch_ack = 2'b00;
        d_ack     = 1'b0;
        if (!reset) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (d_req) begin
                        d_ack = 1'b1;
                    end else if (|fetch_req) begin
                        fetch_ack[w_fetch_pid] = 1'b1;
                    end
                end
                c_ST_WAIT: begin
                    d_ack = d_req & d_write;
                end
                default: begin
                    fetch_ack = 2'b00;
                    d_ack     = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr         <= 1'b0;
            r_wd         <= '0;
            r_strobe     <= 1'b0;
            r_rnotw      <= 1'b1;
            r_addr       <= 16'h0000;
            r_wdata      <= 16'h0000;
            r_rec_pid    <= 1'b0;
            r_rec_load   <= 1'b0;
            r_rec_tag    <= 9'h000;
            r_resp_valid <= 1'b0;
            r_resp_pid   <= 1'b0;
            r_resp_load  <= 1'b0;
            r_resp_tag   <= 9'h000;
            r_resp_data  <= 16'h0000;
            r_err        <= 1'b0;
        end else begin
            r_strobe     <= w_any_grant;
            r_resp_valid <= 1'b0;

            if (w_any_grant) begin
                r_addr  <= w_grant_addr;
                r_rnotw <= w_read_grant;
            end

            if (w_store_grant) begin
                r_wdata <= d_wdata;
            end

            if (w_read_grant) begin
                r_rec_pid  <= d_ack ? d_pid : fetch_ack[1];
                r_rec_load <= d_ack;
                r_rec_tag  <= d_ack ? d_tag : 9'h000;
                r_wd       <= '0;
            end else if (w_in_wait && !mfc && !w_wd_last) begin
                r_wd <= r_wd + c_WD_ONE;
            end

            if (w_in_wait && mfc) begin
                r_resp_valid <= 1'b1;
                r_resp_pid   <= r_rec_pid;
                r_resp_load  <= r_rec_load;
                r_resp_tag   <= r_rec_tag;
                r_resp_data  <= rdata;
            end

            if (w_in_wait && !mfc && w_wd_last) begin
                r_err <= 1'b1;
            end

            if (w_fetch_grant) begin
                r_rr <= ~r_rr;
            end
        end
    end

    assign strobe     = r_strobe;
    assign rnotw      = r_rnotw;
    assign addr       = r_addr;
    assign wdata      = r_wdata;
    assign resp_valid = r_resp_valid;
    assign resp_pid   = r_resp_pid;
    assign resp_load  = r_resp_load;
    assign resp_tag   = r_resp_tag;
    assign resp_data  = r_resp_data;
    assign busy       = w_in_wait;
    assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_initiator.sv
//==============================================================================
// Module      : tb_mem_initiator
// Description : Directed and random checks of mem_initiator against a
//               transaction-level model with a slowmem responder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_initiator;

    localparam int MEMDELAY = 4;
    localparam int TIMEOUT  = MEMDELAY + 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  fetch_req;
    logic [15:0] fetch_addr0, fetch_addr1;
    logic [1:0]  fetch_ack;
    logic        d_req, d_write, d_pid, d_ack;
    logic [15:0] d_addr, d_wdata;
    logic [8:0]  d_tag;
    logic        strobe, rnotw, mfc;
    logic [15:0] addr, wdata, rdata;
    logic        resp_valid, resp_pid, resp_load, busy, err;
    logic [8:0]  resp_tag;
    logic [15:0] resp_data;

    always #5 clk = ~clk;

    mem_initiator #(.MEMDELAY(MEMDELAY), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr0(fetch_addr0), .fetch_addr1(fetch_addr1),
        .fetch_ack(fetch_ack),
        .d_req(d_req), .d_write(d_write), .d_pid(d_pid), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_tag(d_tag), .d_ack(d_ack),
        .strobe(strobe), .rnotw(rnotw), .addr(addr), .wdata(wdata),
        .mfc(mfc), .rdata(rdata),
        .resp_valid(resp_valid), .resp_pid(resp_pid), .resp_load(resp_load),
        .resp_tag(resp_tag), .resp_data(resp_data), .busy(busy), .err(err)
    );

    int vectors = 0;
    int miscompares = 0;

    // Transaction-level model: one outstanding read, with age in cycles.
    bit          m_outst, m_rr, m_err, m_strobe, m_rnotw, m_rv, m_rpid, m_rload;
    int          m_age;
    logic [15:0] m_addr, m_wdata, m_rdata;
    logic [8:0]  m_rtag;
    bit          o_pid, o_load;
    logic [8:0]  o_tag;
    logic [1:0]  e_fack;
    bit          e_dack;

    // slowmem responder
    logic [15:0] mem [logic [15:0]];
    int          cyc = 0;
    int          mfc_at = -1;
    logic [15:0] mfc_addr;
    bit          suppress = 0;
    bit          rand_mode = 0;
    bit          spurious;

    logic [1:0]  drop_f;
    bit          drop_d;

    logic [1:0]  s_fack;
    logic        s_dack, s_strobe, s_rnotw, s_rv, s_rpid, s_rload, s_busy, s_err;
    logic [15:0] s_addr, s_rdata;
    logic [8:0]  s_rtag;

    function automatic logic [15:0] rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 16'h5A5A);
    endfunction

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", n, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_outst = 0; m_rr = 0; m_err = 0; m_strobe = 0; m_rnotw = 1; m_rv = 0;
        m_rpid = 0; m_rload = 0; m_age = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
        m_rtag = 0; o_pid = 0; o_load = 0; o_tag = 0;
    endfunction

    function automatic void model_grant();
        e_fack = 2'b00;
        e_dack = 0;
        if (reset) return;
        if (!m_outst) begin
            if (d_req) e_dack = 1;
            else if (fetch_req == 2'b11) e_fack = m_rr ? 2'b10 : 2'b01;
            else e_fack = fetch_req;
        end else begin
            e_dack = d_req && d_write;
        end
    endfunction

    function automatic void model_update();
        bit fg, rg;
        // memory side sees the bus as it was during the ending cycle
        if (m_strobe && !m_rnotw) mem[m_addr] = m_wdata;
        if (m_strobe && m_rnotw) begin
            if (suppress || (rand_mode && ($urandom % 8 == 0))) mfc_at = -1;
            else mfc_at = cyc + MEMDELAY;
            mfc_addr = m_addr;
        end
        if (reset) begin
            model_reset();
            return;
        end
        fg = |e_fack;
        rg = fg || (e_dack && !d_write);
        m_rv = 0;
        if (m_outst) begin
            if (mfc) begin
                m_rv = 1; m_rdata = rdata; m_rpid = o_pid; m_rload = o_load; m_rtag = o_tag;
                m_outst = 0;
            end else if (m_age + 1 >= TIMEOUT) begin
                m_err = 1;
                m_outst = 0;
            end else begin
                m_age++;
            end
        end
        m_strobe = fg || e_dack;
        if (fg) begin
            m_addr = e_fack[1] ? fetch_addr1 : fetch_addr0;
            m_rnotw = 1;
            o_pid = e_fack[1]; o_load = 0; o_tag = 0;
            m_rr = !m_rr;
        end else if (e_dack) begin
            m_addr = d_addr;
            m_rnotw = !d_write;
            if (d_write) m_wdata = d_wdata;
            else begin o_pid = d_pid; o_load = 1; o_tag = d_tag; end
        end
        if (rg) begin m_outst = 1; m_age = 0; end
        drop_f = e_fack;
        drop_d = e_dack;
    endfunction

    task automatic compare_all();
        check("fetch_ack", {30'd0, s_fack}, {30'd0, e_fack});
        check("d_ack", {31'd0, s_dack}, {31'd0, e_dack});
        check("strobe", {31'd0, s_strobe}, {31'd0, m_strobe});
        check("rnotw", {31'd0, s_rnotw}, {31'd0, m_rnotw});
        check("addr", {16'd0, s_addr}, {16'd0, m_addr});
        check("wdata", {16'd0, wdata}, {16'd0, m_wdata});
        check("resp_valid", {31'd0, s_rv}, {31'd0, m_rv});
        check("resp_pid", {31'd0, s_rpid}, {31'd0, m_rpid});
        check("resp_load", {31'd0, s_rload}, {31'd0, m_rload});
        check("resp_tag", {23'd0, s_rtag}, {23'd0, m_rtag});
        check("resp_data", {16'd0, s_rdata}, {16'd0, m_rdata});
        check("busy", {31'd0, s_busy}, {31'd0, m_outst});
        check("err", {31'd0, s_err}, {31'd0, m_err});
    endtask

    task automatic snap();
        s_fack = fetch_ack; s_dack = d_ack; s_strobe = strobe; s_rnotw = rnotw;
        s_addr = addr; s_rv = resp_valid; s_rpid = resp_pid; s_rload = resp_load;
        s_rtag = resp_tag; s_rdata = resp_data; s_busy = busy; s_err = err;
    endtask

    // One clock: called just after a negedge with requests already driven.
    task automatic tick();
        spurious = rand_mode && !m_outst && ($urandom % 10 == 0);
        mfc = ((mfc_at == cyc) && !suppress) || spurious;
        rdata = (mfc_at == cyc) ? rd(mfc_addr) : 16'($urandom);
        #1;
        snap();
        model_grant();
        compare_all();
        @(posedge clk);
        model_update();
        cyc++;
        @(negedge clk);
        fetch_req = fetch_req & ~drop_f;
        if (drop_d) d_req = 0;
        drop_f = 2'b00;
        drop_d = 0;
    endtask

    task automatic wait_resp(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_rv && n < max);
        check("resp_arrived", {31'd0, s_rv}, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bit seen;
        reset = 1; fetch_req = 0; fetch_addr0 = 0; fetch_addr1 = 0;
        d_req = 0; d_write = 0; d_pid = 0; d_addr = 0; d_wdata = 0; d_tag = 0;
        mfc = 0; rdata = 0; drop_f = 0; drop_d = 0;
        model_reset();
        mem[16'h0000] = 16'h1234; mem[16'h8000] = 16'hABCD;
        mem[16'h0040] = 16'h0440; mem[16'h0002] = 16'h2002;
        @(negedge clk);
        tick(); tick();
        check("reset_rnotw", {31'd0, s_rnotw}, 32'd1);
        check("reset_strobe", {31'd0, s_strobe}, 32'd0);
        reset = 0;

        // both threads fetch: PID 0 first, response 6 cycles after ack
        fetch_req = 2'b11; fetch_addr0 = 16'h0000; fetch_addr1 = 16'h8000;
        tick();
        check("s1_first_ack", {30'd0, s_fack}, 32'd1);
        wait_resp(20, n);
        check("s1_latency", n, 6);
        check("s1_data", {16'd0, s_rdata}, 32'h1234);
        check("s1_pid", {31'd0, s_rpid}, 32'd0);
        check("s1_second_ack", {30'd0, s_fack}, 32'd2);
        tick();
        check("s1_addr1", {16'd0, s_addr}, 32'h8000);
        wait_resp(20, n);
        check("s1_data1", {16'd0, s_rdata}, 32'hABCD);

        // load beats fetch; fetch acked in the response cycle
        d_req = 1; d_write = 0; d_pid = 1; d_addr = 16'h0040; d_tag = 9'h105;
        fetch_req = 2'b01;
        tick();
        check("s2_dack", {31'd0, s_dack}, 32'd1);
        check("s2_fack", {30'd0, s_fack}, 32'd0);
        wait_resp(20, n);
        check("s2_load", {31'd0, s_rload}, 32'd1);
        check("s2_tag", {23'd0, s_rtag}, 32'h105);
        check("s2_data", {16'd0, s_rdata}, 32'h0440);
        check("s2_fetch_in_resp", {30'd0, s_fack}, 32'd1);
        wait_resp(20, n);

        // store to the pending load address, forwarded by slowmem
        d_req = 1; d_write = 0; d_addr = 16'h0040; d_tag = 9'h033; d_pid = 0;
        tick(); tick(); tick();
        d_req = 1; d_write = 1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
        tick();
        check("s3_store_ack", {31'd0, s_dack}, 32'd1);
        wait_resp(20, n);
        check("s3_data", {16'd0, s_rdata}, 32'hBEEF);
        check("s3_err", {31'd0, s_err}, 32'd0);

        // watchdog
        suppress = 1;
        fetch_req = 2'b01; fetch_addr0 = 16'h0002;
        tick();
        n = 0; seen = 0;
        do begin tick(); n++; seen |= s_rv; end while (!s_err && n < 20);
        check("s4_err_after", n, TIMEOUT + 1);
        check("s4_no_resp", {31'd0, seen}, 32'd0);
        check("s4_idle", {31'd0, s_busy}, 32'd0);
        suppress = 0;
        fetch_req = 2'b01;
        tick();
        wait_resp(20, n);
        check("s4_recover", {16'd0, s_rdata}, 32'h2002);

        // async reset with a read outstanding
        fetch_req = 2'b10; fetch_addr1 = 16'h8000;
        tick(); tick(); tick(); tick();
        reset = 1;
        #2;
        check("s5_strobe", {31'd0, strobe}, 32'd0);
        check("s5_busy", {31'd0, busy}, 32'd0);
        check("s5_err", {31'd0, err}, 32'd0);
        check("s5_rnotw", {31'd0, rnotw}, 32'd1);
        check("s5_addr", {16'd0, addr}, 32'd0);
        check("s5_rdata", {16'd0, resp_data}, 32'd0);
        model_reset();
        tick();
        reset = 0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin tick(); seen |= s_rv; end
        check("s5_late_mfc", {31'd0, seen}, 32'd0);
        fetch_req = 2'b11; fetch_addr0 = 16'h0000;
        tick();
        check("s5_pid0_first", {30'd0, s_fack}, 32'd1);
        wait_resp(20, n);
        wait_resp(20, n);

        // back-to-back stores then read back
        d_req = 1; d_write = 1; d_addr = 16'h0010; d_wdata = 16'h1111;
        tick();
        check("s6_ack1", {31'd0, s_dack}, 32'd1);
        d_req = 1; d_write = 1; d_addr = 16'h0011; d_wdata = 16'h2222;
        tick();
        check("s6_strobe1", {15'd0, s_strobe, s_rnotw, s_addr}, {15'd0, 1'b1, 1'b0, 16'h0010});
        check("s6_ack2", {31'd0, s_dack}, 32'd1);
        tick();
        check("s6_strobe2", {15'd0, s_strobe, s_rnotw, s_addr}, {15'd0, 1'b1, 1'b0, 16'h0011});
        d_req = 1; d_write = 0; d_addr = 16'h0011; d_tag = 9'h011;
        tick();
        wait_resp(20, n);
        check("s6_readback", {16'd0, s_rdata}, 32'h2222);

        // random traffic on a small address window to provoke forwarding
        reset = 1; model_reset(); tick(); reset = 0;
        rand_mode = 1;
        for (int i = 0; i < 2500; i++) begin
            if (!d_req && ($urandom % 4 == 0)) begin
                d_req = 1; d_write = 1'($urandom); d_pid = 1'($urandom);
                d_addr = 16'($urandom % 32); d_wdata = 16'($urandom); d_tag = 9'($urandom);
            end
            if (!fetch_req[0] && ($urandom % 3 == 0)) begin
                fetch_req[0] = 1; fetch_addr0 = 16'($urandom % 32);
            end
            if (!fetch_req[1] && ($urandom % 3 == 0)) begin
                fetch_req[1] = 1; fetch_addr1 = 16'($urandom % 32);
            end
            tick();
        end
        rand_mode = 0;
        fetch_req = 0; d_req = 0;
        for (int i = 0; i < 12; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_initiator.md
# mem_initiator

Request initiator for the `slowmem` strobe/mfc protocol. It takes instruction-fetch requests from both hardware threads (PID 0/1) and load/store requests from pipeline stage s3. It arbitrates among them and drives `strobe`/`rnotw`/`addr`/`wdata` toward `slowmem`. When each read completes, it returns tagged read data (thread, fetch-or-load, destination register) to the pipeline, replacing the ad-hoc request logic currently in the processor's fetch block.

## Interface
Parameters:
- MEMDELAY, 4, `slowmem` read latency in cycles; sets the watchdog limit.
- TIMEOUT, MEMDELAY+3, cycles in WAIT without `mfc` before an error is declared.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- fetch_req  in  2  per-PID instruction fetch request (level, held until acked).
- fetch_addr0 / fetch_addr1  in  16 each  fetch PC for PID 0 / PID 1.
- fetch_ack  out  2  one-cycle combinational grant, at most one bit set.
- d_req  in  1  data request (level, held until acked).
- d_write  in  1  1 = store, 0 = load.
- d_pid  in  1  issuing thread.
- d_addr  in  16  data address.
- d_wdata  in  16  store data.
- d_tag  in  9  load destination register {pid, reg}.
- d_ack  out  1  one-cycle combinational grant.
- strobe  out  1  memory strobe.
- rnotw  out  1  1 = read, 0 = write.
- addr  out  16  memory address.
- wdata  out  16  memory write data.
- mfc  in  1  memory function complete.
- rdata  in  16  memory read data.
- resp_valid  out  1  one-cycle read-response pulse.
- resp_pid  out  1  thread of the response.
- resp_load  out  1  1 = load response, 0 = fetch response.
- resp_tag  out  9  echoed `d_tag` (0 for fetches).
- resp_data  out  16  returned word.
- busy  out  1  a read is outstanding.
- err  out  1  sticky watchdog error.

## Operation
- States:
  - IDLE: nothing outstanding.
  - WAIT: one read outstanding.
  - At most one read is outstanding at any time.
- Arbitration in IDLE, priority order:
  1. `d_req`.
  2. `fetch_req`, round-robin between PIDs. The `rr` pointer flips after each granted fetch. Reset value of `rr` = 0 (PID 0 first).
- Grant in IDLE:
  - The `ack` bit is high in the grant cycle.
  - At that posedge the block registers `strobe`=1, `addr`, and `rnotw` (`wdata` for stores).
  - It also latches `{pid, load, tag}` into the outstanding record.
- Read grant: next state WAIT, `busy`=1.
- Store grant: state stays IDLE.
- In WAIT:
  - `fetch_req` and loads are not acked.
  - A store (`d_req && d_write`) is acked and issued as a one-cycle write strobe. State remains WAIT.
  - `slowmem` forwards the data itself when the store address equals the pending read address; the block takes no action for this case.
- `strobe` is high for exactly one cycle per request. `addr`/`rnotw`/`wdata` hold their values until the next grant.
- Completion: when `mfc`=1 is sampled in WAIT:
  - Register `resp_valid`=1 with `resp_data`=`rdata` and the outstanding record.
  - Clear `busy`; next state IDLE.
- `mfc` sampled in IDLE is ignored (stale completion after reset or timeout).
- Watchdog: a counter clears on entry to WAIT and increments each cycle in WAIT. When it reaches TIMEOUT:
  - Set `err`=1 (sticky until reset).
  - Return to IDLE with no `resp_valid`.
- Simultaneous `mfc` and store request in WAIT: both are honoured in the same cycle (response registered and write strobe issued).
- A store is never granted in the same cycle a read is granted.
- Reset values: `strobe`=0, `rnotw`=1, `addr`=0, `wdata`=0, `resp_valid`=0, `resp_pid`=0, `resp_load`=0, `resp_tag`=0, `resp_data`=0, `busy`=0, `err`=0, `rr`=0, state IDLE, watchdog=0.
- Reset mid-WAIT abandons the outstanding read. A later `mfc` is ignored per the IDLE rule.

## Timing
- Read grant in cycle T (ack high):
  - `strobe` high during T+1.
  - `slowmem` captures the request at posedge ending T+1.
  - `mfc` high during T+5.
  - `resp_valid` high during T+6.
  - Accept-to-response latency: 6 cycles.
  - Earliest next read grant: T+6.
- Store grant in cycle T: `strobe`=1, `rnotw`=0 during T+1. Memory is written at the posedge ending T+1. The next grant can be in T+1.
- `ack` outputs are combinational from the request inputs, current state, and `rr`. They must not depend on `mfc`.
- `resp_*` fields are valid only while `resp_valid`=1 and hold their values afterwards.

## Test plan
- Reset, then `fetch_req`=2'b11 with addr0=0x0000, addr1=0x8000 -> PID 0 acked first. `strobe` for one cycle with `addr`=0x0000, `rnotw`=1. `resp_valid` 6 cycles after ack with `resp_pid`=0, `resp_data`=m[0]. Then PID 1 acked with `addr`=0x8000.
- `d_req` load (addr 0x0040, tag 9'h105) concurrent with `fetch_req`=2'b01 -> `d_ack` wins. Response has `resp_load`=1, `resp_tag`=9'h105, data m[0x40]. The fetch is acked in the cycle of `resp_valid`.
- Load 0x0040 outstanding, store 0x0040 := 0xBEEF issued 2 cycles later -> store acked in WAIT. `resp_data`=0xBEEF arrives early (forwarded), and `err` stays 0.
- Memory model suppresses `mfc` -> `err`=1 after TIMEOUT (7) cycles in WAIT, no `resp_valid`, state IDLE. A subsequent fetch still completes normally.
- Assert `reset` 3 cycles after a read grant -> all outputs at reset values immediately. The late `mfc` produces no `resp_valid`. The next fetch grants PID 0.
- Back-to-back stores to 0x10/0x11 (0x1111/0x2222) -> two consecutive one-cycle strobes with `rnotw`=0. A subsequent read of 0x11 returns 0x2222.
